// File: rtl/fu_branch_queue.sv
// In-order branch resolution queue: ops wait for operands via CDB wakeup,
// the head resolves into a registered valid/ready output stage.
module fu_branch_queue #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int ROB_W     = 5,
    parameter int CDB_WIDTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [2:0]                 in_func3,
    input  logic                       in_cond,
    input  logic                       in_uncond,
    input  logic                       in_jalr,
    input  logic [XLEN-1:0]            in_rs1_val,
    input  logic [XLEN-1:0]            in_rs2_val,
    input  logic                       in_rs1_rdy,
    input  logic                       in_rs2_rdy,
    input  logic [TAG_W-1:0]           in_rs1_tag,
    input  logic [TAG_W-1:0]           in_rs2_tag,
    input  logic                       in_pred_taken,
    input  logic [XLEN-1:0]            in_pred_target,
    input  logic [ROB_W-1:0]           in_rob_idx,
    input  logic [CDB_WIDTH-1:0]       cdb_valid,
    input  logic [CDB_WIDTH*TAG_W-1:0] cdb_tag,
    input  logic [CDB_WIDTH*XLEN-1:0]  cdb_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_take,
    output logic [XLEN-1:0]            out_target,
    output logic [XLEN-1:0]            out_npc,
    output logic                       out_mispredict,
    output logic [ROB_W-1:0]           out_rob_idx,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [2:0]       func3;
        logic             cond;
        logic             uncond;
        logic             jalr;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic             rs1_rdy;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic             pred_taken;
        logic [XLEN-1:0]  pred_target;
        logic [ROB_W-1:0] rob_idx;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_e;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             out_valid_q, out_valid_d;
    logic             out_take_q, out_take_d;
    logic [XLEN-1:0]  out_target_q, out_target_d;
    logic [XLEN-1:0]  out_npc_q, out_npc_d;
    logic             out_mispredict_q, out_mispredict_d;
    logic [ROB_W-1:0] out_rob_idx_q, out_rob_idx_d;

    logic [XLEN:0]    snp1 [DEPTH];
    logic [XLEN:0]    snp2 [DEPTH];
    logic [XLEN:0]    snp_in1, snp_in2;

    logic             enq, deq, head_rdy;
    logic [XLEN-1:0]  op_a, sum;
    logic [XLEN-1:0]  res_target, res_npc;
    logic             cond_hit, res_take, res_mispredict;

    // {hit, value}; scanning high to low lets the lowest channel win
    function automatic logic [XLEN:0] cdb_snoop(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int k = CDB_WIDTH - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                r = {1'b1, cdb_value[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    always_comb begin
        snp_in1 = cdb_snoop(in_rs1_tag);
        snp_in2 = cdb_snoop(in_rs2_tag);
        for (int i = 0; i < DEPTH; i++) begin
            snp1[i] = cdb_snoop(ent_q[i].rs1_tag);
            snp2[i] = cdb_snoop(ent_q[i].rs2_tag);
        end
    end

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign head_rdy = valid_q[head_q] & ent_q[head_q].rs1_rdy
                    & ent_q[head_q].rs2_rdy;
    assign deq = head_rdy & (!out_valid_q | out_ready) & !squash;
    assign enq = in_valid & in_ready & !squash;

    always_comb begin
        op_a = ent_q[head_q].jalr ? ent_q[head_q].rs1_val : ent_q[head_q].pc;
        sum = op_a + ent_q[head_q].imm;
        res_target = ent_q[head_q].jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        res_npc = ent_q[head_q].pc + XLEN'(4);
        case (ent_q[head_q].func3)
            3'b000: cond_hit = ent_q[head_q].rs1_val == ent_q[head_q].rs2_val;
            3'b001: cond_hit = ent_q[head_q].rs1_val != ent_q[head_q].rs2_val;
            3'b100: cond_hit = $signed(ent_q[head_q].rs1_val)
                             < $signed(ent_q[head_q].rs2_val);
            3'b101: cond_hit = $signed(ent_q[head_q].rs1_val)
                             >= $signed(ent_q[head_q].rs2_val);
            3'b110: cond_hit = ent_q[head_q].rs1_val < ent_q[head_q].rs2_val;
            3'b111: cond_hit = ent_q[head_q].rs1_val >= ent_q[head_q].rs2_val;
            default: cond_hit = 1'b0;
        endcase
        res_take = ent_q[head_q].uncond | (ent_q[head_q].cond & cond_hit);
        res_mispredict = (res_take != ent_q[head_q].pred_taken)
                       | (res_take & (res_target != ent_q[head_q].pred_target));
    end

    // Incoming op snoops the CDB in its issue cycle so no wakeup is lost
    always_comb begin
        new_e = '0;
        new_e.pc = in_pc;
        new_e.imm = in_imm;
        new_e.func3 = in_func3;
        new_e.cond = in_cond;
        new_e.uncond = in_uncond;
        new_e.jalr = in_jalr;
        new_e.rs1_tag = in_rs1_tag;
        new_e.rs2_tag = in_rs2_tag;
        new_e.pred_taken = in_pred_taken;
        new_e.pred_target = in_pred_target;
        new_e.rob_idx = in_rob_idx;
        new_e.rs1_rdy = in_rs1_rdy | snp_in1[XLEN];
        new_e.rs2_rdy = in_rs2_rdy | snp_in2[XLEN];
        new_e.rs1_val = in_rs1_rdy ? in_rs1_val
                      : (snp_in1[XLEN] ? snp_in1[XLEN-1:0] : in_rs1_val);
        new_e.rs2_val = in_rs2_rdy ? in_rs2_val
                      : (snp_in2[XLEN] ? snp_in2[XLEN-1:0] : in_rs2_val);
    end

    always_comb begin
        ent_d = ent_q;
        valid_d = valid_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !ent_q[i].rs1_rdy && snp1[i][XLEN]) begin
                ent_d[i].rs1_rdy = 1'b1;
                ent_d[i].rs1_val = snp1[i][XLEN-1:0];
            end
            if (valid_q[i] && !ent_q[i].rs2_rdy && snp2[i][XLEN]) begin
                ent_d[i].rs2_rdy = 1'b1;
                ent_d[i].rs2_val = snp2[i][XLEN-1:0];
            end
        end
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            ent_d[tail_q] = new_e;
            valid_d[tail_q] = 1'b1;
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        if (squash) begin
            valid_d = '0;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_take_d = out_take_q;
        out_target_d = out_target_q;
        out_npc_d = out_npc_q;
        out_mispredict_d = out_mispredict_q;
        out_rob_idx_d = out_rob_idx_q;
        if (squash) begin
            out_valid_d = 1'b0;
            out_take_d = 1'b0;
            out_target_d = '0;
            out_npc_d = '0;
            out_mispredict_d = 1'b0;
            out_rob_idx_d = '0;
        end else if (deq) begin
            out_valid_d = 1'b1;
            out_take_d = res_take;
            out_target_d = res_target;
            out_npc_d = res_npc;
            out_mispredict_d = res_mispredict;
            out_rob_idx_d = ent_q[head_q].rob_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            valid_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            out_valid_q <= 1'b0;
            out_take_q <= 1'b0;
            out_target_q <= '0;
            out_npc_q <= '0;
            out_mispredict_q <= 1'b0;
            out_rob_idx_q <= '0;
        end else begin
            ent_q <= ent_d;
            valid_q <= valid_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            out_valid_q <= out_valid_d;
            out_take_q <= out_take_d;
            out_target_q <= out_target_d;
            out_npc_q <= out_npc_d;
            out_mispredict_q <= out_mispredict_d;
            out_rob_idx_q <= out_rob_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_take = out_take_q;
    assign out_target = out_target_q;
    assign out_npc = out_npc_q;
    assign out_mispredict = out_mispredict_q;
    assign out_rob_idx = out_rob_idx_q;
    assign count = count_q;

endmodule

// File: tb/tb_fu_branch_queue.sv
// Bench for fu_branch_queue: fixed vectors, corner sequences and random
// traffic against a queue-based reference model.
module tb_fu_branch_queue;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int ROB_W = 5;
    localparam int CDB_WIDTH = 2;

    logic              clock, reset, squash, in_valid, in_ready;
    logic [31:0]       in_pc, in_imm, in_rs1_val, in_rs2_val, in_pred_target;
    logic [2:0]        in_func3;
    logic              in_cond, in_uncond, in_jalr;
    logic              in_rs1_rdy, in_rs2_rdy, in_pred_taken;
    logic [5:0]        in_rs1_tag, in_rs2_tag;
    logic [4:0]        in_rob_idx;
    logic [1:0]        cdb_valid;
    logic [11:0]       cdb_tag;
    logic [63:0]       cdb_value;
    logic              out_valid, out_ready, out_take, out_mispredict;
    logic [31:0]       out_target, out_npc;
    logic [4:0]        out_rob_idx;
    logic [2:0]        count;

    fu_branch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W),
        .ROB_W(ROB_W), .CDB_WIDTH(CDB_WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_func3(in_func3),
        .in_cond(in_cond), .in_uncond(in_uncond), .in_jalr(in_jalr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_rob_idx(in_rob_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_take(out_take), .out_target(out_target), .out_npc(out_npc),
        .out_mispredict(out_mispredict), .out_rob_idx(out_rob_idx),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc, imm;
        logic [2:0]  f3;
        logic        c, u, j;
        logic [31:0] v1, v2;
        logic        r1, r2;
        logic [5:0]  t1, t2;
        logic        pt;
        logic [31:0] ptg;
        logic [4:0]  rob;
    } op_t;

    typedef struct {
        logic [31:0] pc, imm, rs1, rs2, ptg;
        logic [2:0]  f3;
        logic        c, u, j, pt;
        logic        e_take;
        logic [31:0] e_tgt, e_npc;
        logic        e_mis;
    } vec_t;

    int total_cnt = 0;
    int pass_cnt = 0;

    op_t         mq[$];
    logic        mov, mtake, mmis;
    logic [31:0] mtgt, mnpc;
    logic [4:0]  mrob;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Lowest matching channel supplies the value
    function automatic logic [32:0] snoop(input logic r, input logic [5:0] t,
                                          input logic [31:0] v);
        if (r) return {1'b1, v};
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cdb_valid[k] && cdb_tag[k*6 +: 6] == t)
                return {1'b1, cdb_value[k*32 +: 32]};
        end
        return {1'b0, v};
    endfunction

    // {take, mispredict, target, npc}
    function automatic logic [65:0] resolve(input op_t o);
        logic [31:0] a, tgt;
        logic        c, take, mis;
        a = o.j ? o.v1 : o.pc;
        tgt = a + o.imm;
        if (o.j) tgt = tgt & 32'hFFFF_FFFE;
        case (o.f3)
            3'd0: c = (o.v1 == o.v2);
            3'd1: c = (o.v1 != o.v2);
            3'd4: c = ($signed(o.v1) < $signed(o.v2));
            3'd5: c = ($signed(o.v1) >= $signed(o.v2));
            3'd6: c = (o.v1 < o.v2);
            3'd7: c = (o.v1 >= o.v2);
            default: c = 1'b0;
        endcase
        take = o.u | (o.c & c);
        mis = (take != o.pt) || (take && tgt != o.ptg);
        return {take, mis, tgt, o.pc + 32'd4};
    endfunction

    task automatic model_step();
        bit          rdy_pre;
        logic [32:0] s;
        op_t         n;
        rdy_pre = mq.size() < DEPTH;
        if (reset || squash) begin
            mq.delete();
            mov = 0; mtake = 0; mmis = 0; mtgt = 0; mnpc = 0; mrob = 0;
            return;
        end
        if (mq.size() > 0 && mq[0].r1 && mq[0].r2 && (!mov || out_ready)) begin
            {mtake, mmis, mtgt, mnpc} = resolve(mq[0]);
            mrob = mq[0].rob;
            mov = 1;
            void'(mq.pop_front());
        end else if (out_ready) begin
            mov = 0;
        end
        foreach (mq[i]) begin
            s = snoop(mq[i].r1, mq[i].t1, mq[i].v1);
            mq[i].r1 = s[32]; mq[i].v1 = s[31:0];
            s = snoop(mq[i].r2, mq[i].t2, mq[i].v2);
            mq[i].r2 = s[32]; mq[i].v2 = s[31:0];
        end
        if (in_valid && rdy_pre) begin
            n.pc = in_pc; n.imm = in_imm; n.f3 = in_func3;
            n.c = in_cond; n.u = in_uncond; n.j = in_jalr;
            n.t1 = in_rs1_tag; n.t2 = in_rs2_tag;
            n.pt = in_pred_taken; n.ptg = in_pred_target; n.rob = in_rob_idx;
            s = snoop(in_rs1_rdy, in_rs1_tag, in_rs1_val);
            n.r1 = s[32]; n.v1 = s[31:0];
            s = snoop(in_rs2_rdy, in_rs2_tag, in_rs2_val);
            n.r2 = s[32]; n.v2 = s[31:0];
            mq.push_back(n);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mov));
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        if (mov) begin
            chk("m_take", 32'(out_take), 32'(mtake));
            chk("m_target", out_target, mtgt);
            chk("m_npc", out_npc, mnpc);
            chk("m_mispredict", 32'(out_mispredict), 32'(mmis));
            chk("m_rob", 32'(out_rob_idx), 32'(mrob));
        end
    endtask

    task automatic drive(input op_t o);
        in_valid = 1'b1;
        in_pc = o.pc; in_imm = o.imm; in_func3 = o.f3;
        in_cond = o.c; in_uncond = o.u; in_jalr = o.j;
        in_rs1_val = o.v1; in_rs2_val = o.v2;
        in_rs1_rdy = o.r1; in_rs2_rdy = o.r2;
        in_rs1_tag = o.t1; in_rs2_tag = o.t2;
        in_pred_taken = o.pt; in_pred_target = o.ptg; in_rob_idx = o.rob;
    endtask

    function automatic op_t beq_op(input logic [4:0] rob, input logic r2,
                                   input logic [5:0] t2);
        op_t o;
        o.pc = 32'h1000 + 32'(rob) * 32'h10; o.imm = 32'h20; o.f3 = 3'd0;
        o.c = 1; o.u = 0; o.j = 0;
        o.v1 = 32'd9; o.v2 = r2 ? 32'd9 : 32'd0;
        o.r1 = 1; o.r2 = r2; o.t1 = 6'd0; o.t2 = t2;
        o.pt = 0; o.ptg = 0; o.rob = rob;
        return o;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 3));
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    vec_t tv[10];
    op_t  o;

    initial begin
        tv[0] = '{32'h100, 32'h20, 32'd5, 32'd5, 32'h0, 3'b000,
                  1, 0, 0, 0, 1, 32'h120, 32'h104, 1};
        tv[1] = '{32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h240, 3'b100,
                  1, 0, 0, 1, 1, 32'h240, 32'h204, 0};
        tv[2] = '{32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0, 3'b110,
                  1, 0, 0, 0, 0, 32'h240, 32'h204, 0};
        tv[3] = '{32'h300, 32'h4, 32'h1003, 32'd0, 32'h1006, 3'b000,
                  0, 1, 1, 1, 1, 32'h1006, 32'h304, 0};
        tv[4] = '{32'h400, 32'hFFFF_FFF0, 32'd7, 32'd7, 32'h3F0, 3'b001,
                  1, 0, 0, 1, 0, 32'h3F0, 32'h404, 1};
        tv[5] = '{32'h500, 32'h8, 32'd1, 32'hFFFF_FFFF, 32'h50C, 3'b101,
                  1, 0, 0, 1, 1, 32'h508, 32'h504, 1};
        tv[6] = '{32'h600, 32'h10, 32'd1, 32'hFFFF_FFFF, 32'h0, 3'b111,
                  1, 0, 0, 0, 0, 32'h610, 32'h604, 0};
        tv[7] = '{32'h700, 32'h4, 32'd3, 32'd3, 32'h0, 3'b010,
                  1, 0, 0, 0, 0, 32'h704, 32'h704, 0};
        tv[8] = '{32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 32'h4, 3'b000,
                  0, 1, 0, 1, 1, 32'h4, 32'h0, 0};
        tv[9] = '{32'h800, 32'h0, 32'd1, 32'd2, 32'h0, 3'b000,
                  0, 0, 0, 0, 0, 32'h800, 32'h804, 0};

        reset = 1; squash = 0; out_ready = 1;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        o = beq_op(5'd0, 1'b1, 6'd0);
        drive(o);
        cycle();
        cycle();
        reset = 0; in_valid = 0;
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_take", 32'(out_take), 32'd0);
        chk("rst_target", out_target, 32'd0);
        chk("rst_npc", out_npc, 32'd0);
        chk("rst_mis", 32'(out_mispredict), 32'd0);
        chk("rst_rob", 32'(out_rob_idx), 32'd0);

        for (int i = 0; i < 10; i++) begin
            o.pc = tv[i].pc; o.imm = tv[i].imm; o.f3 = tv[i].f3;
            o.c = tv[i].c; o.u = tv[i].u; o.j = tv[i].j;
            o.v1 = tv[i].rs1; o.v2 = tv[i].rs2; o.r1 = 1; o.r2 = 1;
            o.t1 = 0; o.t2 = 0; o.pt = tv[i].pt; o.ptg = tv[i].ptg;
            o.rob = 5'(i);
            drive(o);
            cycle();
            in_valid = 0;
            cycle();
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_take", 32'(out_take), 32'(tv[i].e_take));
            chk("vec_target", out_target, tv[i].e_tgt);
            chk("vec_npc", out_npc, tv[i].e_npc);
            chk("vec_mis", 32'(out_mispredict), 32'(tv[i].e_mis));
            chk("vec_rob", 32'(out_rob_idx), 32'(i));
            cycle();
        end

        // fill with pending rs2 tag 7, pointers wrap past the end
        for (int i = 0; i < 4; i++) begin
            drive(beq_op(5'(10 + i), 1'b0, 6'd7));
            cycle();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        drive(beq_op(5'd14, 1'b1, 6'd0));
        cycle();
        chk("full_drop", 32'(count), 32'd4);
        in_valid = 0;
        cdb_valid = 2'b11; cdb_tag = {6'd7, 6'd3};
        cdb_value = {32'd9, 32'd55};
        cycle();
        cdb_valid = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wake_valid", 32'(out_valid), 32'd1);
            chk("wake_rob", 32'(out_rob_idx), 32'(10 + i));
            chk("wake_take", 32'(out_take), 32'd1);
        end
        cycle();

        // output stall holds results and the head
        out_ready = 0;
        drive(beq_op(5'd20, 1'b1, 6'd0));
        cycle();
        drive(beq_op(5'd21, 1'b1, 6'd0));
        cycle();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_rob", 32'(out_rob_idx), 32'd20);
            chk("stall_target", out_target, 32'h1160);
            chk("stall_count", 32'(count), 32'd1);
        end
        out_ready = 1;
        cycle();
        chk("stall_next", 32'(out_rob_idx), 32'd21);
        cycle();

        // squash with queued entries, held output and a new issue
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(beq_op(5'(24 + i), 1'b1, 6'd0));
            cycle();
        end
        chk("pre_sq_count", 32'(count), 32'd3);
        chk("pre_sq_valid", 32'(out_valid), 32'd1);
        squash = 1;
        drive(beq_op(5'd28, 1'b1, 6'd0));
        cycle();
        chk("sq_count", 32'(count), 32'd0);
        chk("sq_valid", 32'(out_valid), 32'd0);
        chk("sq_target", out_target, 32'd0);
        chk("sq_rob", 32'(out_rob_idx), 32'd0);
        squash = 0; in_valid = 0; out_ready = 1;
        cycle();
        chk("sq_dropped", 32'(count), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            o.pc = $urandom() & 32'hFFFF_FFFC;
            o.imm = 32'($signed(12'($urandom_range(0, 4095))));
            o.f3 = 3'($urandom_range(0, 7));
            o.c = 1'($urandom_range(0, 1));
            o.u = ($urandom_range(0, 3) == 0);
            o.j = 1'($urandom_range(0, 1));
            o.v1 = rnd_val(); o.v2 = rnd_val();
            o.r1 = 1'($urandom_range(0, 1)); o.r2 = 1'($urandom_range(0, 1));
            o.t1 = 6'($urandom_range(0, 7)); o.t2 = 6'($urandom_range(0, 7));
            o.pt = 1'($urandom_range(0, 1));
            o.ptg = ($urandom_range(0, 1) == 1) ? (o.pc + o.imm) : $urandom();
            o.rob = 5'($urandom_range(0, 31));
            drive(o);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cdb_valid = 2'($urandom_range(0, 3));
            cdb_tag = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            cdb_value = {rnd_val(), rnd_val()};
            squash = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 511) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
